// File: rtl/console_text_buffer.sv
// console_text_buffer: 8x16 character/attribute cell store read by pixel position and
// written by a terminal-style byte stream with cursor, wrap, scroll and clear.
module console_text_buffer #(
    parameter int          COLS       = 80,
    parameter int          ROWS       = 30,
    parameter logic [7:0]  CLEAR_ATTR = 8'h0F
) (
    input  logic       CLK_PIXEL,
    input  logic       reset,
    input  logic [9:0] cx,
    input  logic [9:0] cy,
    output logic [7:0] character,
    output logic [7:0] attribute,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    input  logic [7:0] in_attr,
    output logic [6:0] cursor_col,
    output logic [4:0] cursor_row
);
    localparam int          CELLS      = COLS * ROWS;
    localparam logic [11:0] L_COLS     = 12'(COLS);
    localparam logic [11:0] L_LAST     = 12'(CELLS - 1);
    localparam logic [15:0] CLEAR_CELL = {CLEAR_ATTR, 8'h20};

    typedef enum logic [1:0] {IDLE, CLEAR_ROW, CLEAR_ALL} state_t;

    logic [15:0] r_mem [CELLS];
    state_t      r_state, w_state_nxt;
    logic [6:0]  r_col, w_col_nxt;
    logic [4:0]  r_row, w_row_nxt, r_top, w_top_nxt;
    logic [11:0] r_clr, w_clr_nxt, r_end, w_end_nxt;
    logic [11:0] w_waddr, w_raddr, w_cur_addr, w_top_base;
    logic [15:0] w_wdata;
    logic        w_we, w_adv, w_vis;
    logic [7:0]  r_char, r_attr;

    // Logical row plus scroll offset, folded back into 0..ROWS-1, then linearised.
    function automatic logic [11:0] f_addr(input logic [5:0] row, input logic [4:0] top,
                                           input logic [6:0] col);
        logic [6:0] sum;
        sum = 7'(row) + 7'(top);
        if (sum >= 7'(ROWS)) sum = sum - 7'(ROWS);
        return 12'(sum) * L_COLS + 12'(col);
    endfunction

    assign w_vis      = (cx < 10'(COLS * 8)) && (cy < 10'(ROWS * 16));
    assign w_raddr    = f_addr(cy[9:4], r_top, cx[9:3]);
    assign w_cur_addr = f_addr({1'b0, r_row}, r_top, r_col);
    assign w_top_base = 12'(r_top) * L_COLS;
    assign in_ready   = (r_state == IDLE) && !reset;
    assign character  = r_char;
    assign attribute  = r_attr;
    assign cursor_col = r_col;
    assign cursor_row = r_row;

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_top_nxt   = r_top;
        w_clr_nxt   = r_clr;
        w_end_nxt   = r_end;
        w_we        = 1'b0;
        w_waddr     = r_clr;
        w_wdata     = CLEAR_CELL;
        w_adv       = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (in_char == 8'h0A) begin
                        w_col_nxt = 7'd0;
                        w_adv     = 1'b1;
                    end else if (in_char == 8'h0D) begin
                        w_col_nxt = 7'd0;
                    end else if (in_char == 8'h08) begin
                        w_col_nxt = (r_col != 7'd0) ? r_col - 7'd1 : r_col;
                    end else if (in_char == 8'h0C) begin
                        w_col_nxt   = 7'd0;
                        w_row_nxt   = 5'd0;
                        w_top_nxt   = 5'd0;
                        w_clr_nxt   = 12'd0;
                        w_end_nxt   = L_LAST;
                        w_state_nxt = CLEAR_ALL;
                    end else begin
                        w_we      = 1'b1;
                        w_waddr   = w_cur_addr;
                        w_wdata   = {in_attr, in_char};
                        w_col_nxt = (r_col < 7'(COLS - 1)) ? r_col + 7'd1 : 7'd0;
                        w_adv     = (r_col >= 7'(COLS - 1));
                    end
                end
            end
            default: begin
                w_we        = 1'b1;
                w_clr_nxt   = r_clr + 12'd1;
                w_state_nxt = (r_clr == r_end) ? IDLE : r_state;
            end
        endcase
        // Scrolling: the old top physical row becomes the new bottom row and is blanked.
        if (w_adv) begin
            if (r_row < 5'(ROWS - 1)) begin
                w_row_nxt = r_row + 5'd1;
            end else begin
                w_top_nxt   = (r_top == 5'(ROWS - 1)) ? 5'd0 : r_top + 5'd1;
                w_clr_nxt   = w_top_base;
                w_end_nxt   = w_top_base + L_COLS - 12'd1;
                w_state_nxt = CLEAR_ROW;
            end
        end
    end

    always_ff @(posedge CLK_PIXEL) begin
        if (reset) begin
            r_state <= CLEAR_ALL;
            r_clr   <= 12'd0;
            r_end   <= L_LAST;
            r_col   <= 7'd0;
            r_row   <= 5'd0;
            r_top   <= 5'd0;
            r_char  <= 8'h00;
            r_attr  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_clr   <= w_clr_nxt;
            r_end   <= w_end_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_top   <= w_top_nxt;
            r_char  <= w_vis ? r_mem[w_raddr][7:0] : 8'h00;
            r_attr  <= w_vis ? r_mem[w_raddr][15:8] : 8'h00;
        end
    end

    always_ff @(posedge CLK_PIXEL) begin
        if (w_we && !reset) r_mem[w_waddr] <= w_wdata;
    end
endmodule

// File: doc/console_text_buffer.md
Name: console_text_buffer

Overview:
- Character/attribute cell store that feeds the console renderer: translates pixel coordinates (cx, cy) into the character and attribute of the 8x16 cell under the beam.
- Write side is a terminal-style byte stream with valid/ready handshake: cursor tracking, line wrap, newline/CR/backspace/form-feed, and hardware scroll via a top-row offset.
- Sits between any text producer (counter formatter, UART bridge) and the console stage, all on CLK_PIXEL.

Parameters:
- COLS, 80, text columns (640 px / 8).
- ROWS, 30, text rows (480 px / 16).
- CLEAR_ATTR, 8'h0F, attribute written into cleared cells; cleared character is always 8'h20.

Ports:
- CLK_PIXEL  input  1  pixel clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cx  input  10  current pixel x.
- cy  input  10  current pixel y.
- character  output  8  cell character for (cx, cy), registered.
- attribute  output  8  cell attribute for (cx, cy), registered.
- in_valid  input  1  write stream byte valid.
- in_ready  output  1  block can accept a byte this cycle.
- in_char  input  8  byte or control code.
- in_attr  input  8  attribute stored with a printable byte.
- cursor_col  output  7  current cursor column, 0..COLS-1.
- cursor_row  output  5  current logical cursor row, 0..ROWS-1.

Behaviour:
- Storage: COLS*ROWS entries of 16 bits {attr, char}, one read port and one write port.
- Read path:
  - col = cx[9:3], row = cy[9:4].
  - phys = row + top_row; subtract ROWS if phys >= ROWS.
  - addr = phys*COLS + col.
  - character/attribute valid exactly 1 cycle after cx/cy are presented.
  - If cx >= COLS*8 or cy >= ROWS*16, the next-cycle outputs are 8'h00/8'h00.
  - Read and write to the same address in the same cycle returns the old data (read-before-write).
- Handshake:
  - A byte transfers on a rising edge with in_valid && in_ready.
  - in_ready is 1 only in IDLE.
  - in_char/in_attr are ignored when no transfer occurs.
- States:
  - IDLE: accept bytes.
  - CLEAR_ROW: writes COLS cells, 1 per cycle, then returns to IDLE.
  - CLEAR_ALL: writes COLS*ROWS cells, 1 per cycle, in address order 0 upward, then returns to IDLE.
- Byte decode in IDLE:
  - 8'h0A (LF): col = 0; advance row.
  - 8'h0D (CR): col = 0.
  - 8'h08 (BS): if col > 0 then col = col-1. No cell is written.
  - 8'h0C (FF): cursor = (0,0); top_row = 0; enter CLEAR_ALL.
  - Any other byte: write {in_attr, in_char} at the cursor cell. If col < COLS-1, col+1; else col = 0 and advance row.
- Advance row:
  - If row < ROWS-1: row+1.
  - Otherwise scroll: row stays ROWS-1; top_row = (top_row+1) mod ROWS. The physical row that was top (now the logical bottom row) is cleared via CLEAR_ROW.
  - The printable byte that triggered the wrap is written before the scroll in the same cycle.
- Clear cell value: {CLEAR_ATTR, 8'h20}.
- While clearing, the display read path continues normally. Partially cleared rows are visible; this is acceptable.
- Reset (any cycle, including mid-clear):
  - character = 0, attribute = 0, cursor = (0,0), top_row = 0, in_ready = 0.
  - State forced to CLEAR_ALL from address 0.
  - in_ready rises COLS*ROWS cycles after reset deasserts (2400 with defaults).
- Widths: column counter 7 bits, row/top_row 5 bits, address 12 bits. No intermediate may wrap past ROWS or COLS.

Test Plan:
- Reset, then hold in_valid=1 -> in_ready=0 for exactly 2400 cycles, then 1. Reading any visible cx/cy -> character 8'h20, attribute 8'h0F. cx=640 -> 8'h00/8'h00.
- Write 'A' (8'h41), attr 8'h1E; sweep cx=0..7, cy=0..15 -> 8'h41/8'h1E one cycle after each coordinate. cx=8 -> 8'h20. Cursor reads (1,0).
- Write 80 printable bytes, then 'B' -> cursor wraps to (0,1) after the 80th. 'B' appears at cx=0, cy=16. BS at col 0 leaves cursor (0,1).
- With cursor on row 29, send LF -> in_ready low 80 cycles. Former row-1 text now at cy=0..15. Row 29 reads 8'h20. top_row=1; cursor (0,29).
- Send FF after text fill -> in_ready low 2400 cycles. All cells 8'h20/8'h0F; cursor (0,0); top_row 0.
- Assert reset in the middle of a CLEAR_ROW -> outputs zero next cycle, full 2400-cycle clear restarts. Hold in_valid with random bytes during clears -> no byte accepted.
